divider_2c_seq: RTL and testbench

- Sequential signed fixed-point divider; the inverse operation of the team's combinational 4-bit two's-complement Q2.2 multiplier.
- Computes q = x / y in the same Q(WIDTH-FRAC).FRAC format.
- Rounds toward zero, saturates on overflow and flags divide-by-zero.
- Sits beside the multiplier in the digit-detection datapath for normalisation/scaling; a start/done handshake lets a controller issue one division at a time.

---
 rtl/fixed_pkg.sv | 13 +
 rtl/div_sat_sign.sv | 44 ++++
 rtl/divider_2c_seq.sv | 123 ++++++++++++
 tb/tb_divider_2c_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared defaults and types for the signed Q-format arithmetic blocks.
package fixed_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_FRAC  = 2;
  localparam int Q_MAX = (2 ** (DEF_WIDTH - 1)) - 1;
  localparam int Q_MIN = -(2 ** (DEF_WIDTH - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;
endpackage

// File: rtl/div_sat_sign.sv
// Turns an unsigned magnitude quotient into a saturated signed result,
// or the signed full-scale value on divide-by-zero.
module div_sat_sign
  import fixed_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic [WIDTH+FRAC-1:0] qm,
  input  logic                  sx,
  input  logic                  dz,
  input  logic                  xneg,
  output logic [WIDTH-1:0]      q,
  output logic                  ovf
);
  localparam int DW = WIDTH + FRAC;
  localparam logic [DW-1:0]    LIM_POS = DW'((2 ** (WIDTH - 1)) - 1);
  localparam logic [DW-1:0]    LIM_NEG = DW'(2 ** (WIDTH - 1));
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    q   = '0;
    ovf = 1'b0;
    if (dz) begin
      q = xneg ? MIN_NEG : MAX_POS;
    end else if (!sx) begin
      if (qm > LIM_POS) begin
        q   = MAX_POS;
        ovf = 1'b1;
      end else begin
        q = qm[WIDTH-1:0];
      end
    end else begin
      // A magnitude of exactly 2^(WIDTH-1) still fits as the most negative value.
      if (qm > LIM_NEG) begin
        q   = MIN_NEG;
        ovf = 1'b1;
      end else begin
        q = -qm[WIDTH-1:0];
      end
    end
  end
endmodule

// File: rtl/divider_2c_seq.sv
// Sequential signed fixed-point divider: restoring radix-2 on magnitudes,
// one quotient bit per clock, then sign/saturation fix-up in a final cycle.
module divider_2c_seq
  import fixed_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             ovf,
  output logic             dz
);
  localparam int DW = WIDTH + FRAC;
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  // Handshake: an operation is accepted on a rising edge where start=1 and
  // ready=1; done pulses for one cycle when q/ovf/dz take their new values.
  state_t state;
  state_t state_nxt;

  logic             sx;
  logic             xneg;
  logic             dz_pend;
  logic [WIDTH-1:0] ymag;
  logic [DW-1:0]    dreg;
  logic [WIDTH:0]   rem;
  logic [DW-1:0]    qm;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH+1:0] rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] q_fix;
  logic             ovf_fix;

  assign x_mag  = x[WIDTH-1] ? -x : x;
  assign y_mag  = y[WIDTH-1] ? -y : y;
  assign rem_sh = {rem, dreg[DW-1]};
  assign rem_ge = rem_sh >= {2'b00, ymag};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = (y == '0) ? FIX : CALC;
      end
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sx      <= 1'b0;
      xneg    <= 1'b0;
      dz_pend <= 1'b0;
      ymag    <= '0;
      dreg    <= '0;
      rem     <= '0;
      qm      <= '0;
      cnt     <= '0;
      q       <= '0;
      ovf     <= 1'b0;
      dz      <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sx      <= x[WIDTH-1] ^ y[WIDTH-1];
            xneg    <= x[WIDTH-1];
            dz_pend <= (y == '0);
            ymag    <= y_mag;
            dreg    <= {x_mag, {FRAC{1'b0}}};
            rem     <= '0;
            qm      <= '0;
            cnt     <= '0;
          end
        end
        CALC: begin
          rem  <= rem_ge ? (WIDTH+1)'(rem_sh - {2'b00, ymag}) : (WIDTH+1)'(rem_sh);
          qm   <= {qm[DW-2:0], rem_ge};
          dreg <= dreg << 1;
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          q    <= q_fix;
          ovf  <= ovf_fix;
          dz   <= dz_pend;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  div_sat_sign #(.WIDTH(WIDTH), .FRAC(FRAC)) u_sat (
    .qm   (qm),
    .sx   (sx),
    .dz   (dz_pend),
    .xneg (xneg),
    .q    (q_fix),
    .ovf  (ovf_fix)
  );
endmodule

// File: tb/tb_divider_2c_seq.sv
// Scoreboard bench for divider_2c_seq: driver pushes expected {q,ovf,dz}
// and the done cycle; a negedge monitor pops and compares on every done.
module tb_divider_2c_seq;
  import fixed_pkg::*;

  localparam int DW = 6;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] x;
  logic [3:0] y;
  logic       ready;
  logic       done;
  logic [3:0] q;
  logic       ovf;
  logic       dz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [5:0] exp_q[$];
  int         cyc_q[$];

  divider_2c_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .ready (ready),
    .done  (done),
    .q     (q),
    .ovf   (ovf),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: value = code/4, so q_code = trunc(4*x_code / y_code), then clamp.
  function automatic logic [5:0] model(input logic [3:0] xi, input logic [3:0] yi);
    int xv;
    int yv;
    int qv;
    xv = $signed(xi);
    yv = $signed(yi);
    if (yv == 0) return {(xv < 0) ? 4'b1000 : 4'b0111, 1'b0, 1'b1};
    qv = (xv * 4) / yv;
    if (qv > Q_MAX) return {4'b0111, 1'b1, 1'b0};
    if (qv < Q_MIN) return {4'b1000, 1'b1, 1'b0};
    return {4'(qv), 1'b0, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done q=%b ovf=%b dz=%b at cycle %0d", q, ovf, dz, cyc);
      end else begin
        logic [5:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        if ({q, ovf, dz} !== e || cyc != ec) begin
          errors++;
          $display("FAIL result q/ovf/dz=%b/%b/%b cycle=%0d, expected %b/%b/%b cycle=%0d",
                   q, ovf, dz, cyc, e[5:2], e[1], e[0], ec);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] xi, input logic [3:0] yi, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout ready=%b expected 1", ready);
      return;
    end
    x = xi;
    y = yi;
    start = 1'b1;
    exp_q.push_back(model(xi, yi));
    cyc_q.push_back(cyc + ((yi == 4'b0000) ? 2 : DW + 2));
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_busy ready=%b expected 0", ready);
    end
    if (!hold) start = 1'b0;
    x = 4'($urandom);
    y = 4'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d expected 0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({ready, done, q, ovf, dz} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL %s ready=%b done=%b q=%b ovf=%b dz=%b expected 1 0 0000 0 0",
               name, ready, done, q, ovf, dz);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    repeat (2) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0;

    // Directed cases including sign, truncation, saturation and divide-by-zero.
    issue(4'b0010, 4'b0100, 0); drain();
    issue(4'b1010, 4'b0100, 0); drain();
    issue(4'b0011, 4'b1010, 0); drain();
    issue(4'b1111, 4'b0011, 0); drain();
    issue(4'b0100, 4'b0010, 0); drain();
    issue(4'b1000, 4'b1111, 0); drain();
    issue(4'b1000, 4'b0100, 0); drain();
    issue(4'b0011, 4'b0000, 0); drain();
    issue(4'b1100, 4'b0000, 0); drain();
    issue(4'b0001, 4'b0111, 0); drain();

    // A start pulse while busy must be ignored.
    issue(4'b0110, 4'b0101, 0);
    @(negedge clk);
    x = 4'b1000;
    y = 4'b0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start held high: back-to-back results.
    issue(4'b0101, 4'b0011, 1);
    issue(4'b1001, 4'b0110, 1);
    issue(4'b0111, 4'b0000, 1);
    issue(4'b1110, 4'b1101, 1);
    start = 1'b0;
    drain();

    // Reset mid-CALC discards the operation with no done pulse.
    issue(4'b1101, 4'b0000, 0); drain();
    issue(4'b0011, 4'b0001, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    check_idle("reset_mid_calc");
    repeat (12) @(negedge clk);

    // Randomised operands, occasional zero divisor and held start.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] rx;
      logic [3:0] ry;
      rx = 4'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      issue(rx, ry, $urandom_range(0, 1) == 1);
    end
    start = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
